// File: rtl/packed_frame_rx.sv
// Beat-serial receiver: reassembles LSB-first beats into one FRAME_W-bit frame,
// checks frame length against s_last and presents the frame on valid/ready.
module packed_frame_rx #(
    parameter int BEAT_W  = 8,
    parameter int FRAME_W = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BEAT_W-1:0]  s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [FRAME_W-1:0] m_frame,
    output logic               m_xz,
    output logic               err_short,
    output logic               err_long
);

    localparam int NBEATS = (FRAME_W + BEAT_W - 1) / BEAT_W;
    localparam int ASM_W  = NBEATS * BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               xz_acc_q, xz_acc_d;
    logic               m_xz_q, m_xz_d;
    logic               err_short_q, err_short_d;
    logic               err_long_q, err_long_d;
    logic               accept;
    logic               beat_xz;

    // X/Z detection only has meaning in a four-state simulator.
`ifdef SYNTHESIS
    assign beat_xz = 1'b0;
`else
    assign beat_xz = $isunknown(s_data);
`endif

    assign s_ready   = (state_q != HOLD);
    assign m_valid   = (state_q == HOLD);
    assign accept    = s_valid && s_ready;
    assign m_frame   = frame_q;
    assign m_xz      = m_xz_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        frame_d     = frame_q;
        xz_acc_d    = xz_acc_q;
        m_xz_d      = m_xz_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    asm_d[cnt_q*BEAT_W +: BEAT_W] = s_data;
                    if (s_last && cnt_q == LAST_CNT) begin
                        state_d  = HOLD;
                        cnt_d    = '0;
                        frame_d  = asm_d[FRAME_W-1:0];
                        m_xz_d   = xz_acc_q | beat_xz;
                        xz_acc_d = 1'b0;
                    end else if (s_last) begin
                        err_short_d = 1'b1;
                        cnt_d       = '0;
                        xz_acc_d    = 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        err_long_d = 1'b1;
                        state_d    = DRAIN;
                        cnt_d      = '0;
                        xz_acc_d   = 1'b0;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        xz_acc_d = xz_acc_q | beat_xz;
                    end
                end
            end
            HOLD: begin
                if (m_ready) state_d = COLLECT;
            end
            DRAIN: begin
                if (accept && s_last) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            frame_q     <= '0;
            xz_acc_q    <= 1'b0;
            m_xz_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            xz_acc_q    <= xz_acc_d;
            m_xz_q      <= m_xz_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    // NOTE: the assembly buffer is not reset; every slice is rewritten before a frame is presented.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

endmodule
